round_sched_cu: RTL and testbench

Round-level scheduler for the encoder core. It runs each of the five permutation stage controllers (theta, rho, pi, chi, add_rc) in order for NUM_ROUNDS rounds, using each stage's start/done handshake. It drives the round index consumed by the add_rc round-constant lookup and the ping-pong buffer select shared by all stage datapaths. It sits between the top-level encoder control and the per-stage controllers.

---
 rtl/round_sched_cu.sv | 106 ++++++++++
 tb/tb_round_sched_cu.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_sched_cu.sv
// Round-level scheduler: sequences the five permutation stages (theta, rho,
// pi, chi, add_rc) for NUM_ROUNDS rounds over a start/done handshake, and
// drives the round index and the ping-pong buffer select for the datapaths.
module round_sched_cu #(
    parameter int unsigned NUM_ROUNDS = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] stage_done,
    output logic [4:0] stage_start,
    output logic [4:0] round,
    output logic       buf_sel,
    output logic       busy,
    output logic       done
);

    localparam int unsigned NSTG  = 5;
    localparam int unsigned STG_W = 3;
    localparam int unsigned RND_W = 5;

    localparam logic [STG_W-1:0] LAST_STG = STG_W'(NSTG - 1);
    localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS - 1);
    localparam logic [NSTG-1:0]  FIRST_OH = NSTG'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        ARM     = 3'd2,
        WAIT    = 3'd3,
        ADVANCE = 3'd4
    } state_t;

    state_t           ps;
    logic [STG_W-1:0] stg;
    logic             act_done;

    // Only the active stage's done flag steers the sequence.
    assign act_done = stage_done[stg];

    // Sequencer with registered Moore outputs, updated alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps          <= IDLE;
            stg         <= '0;
            round       <= '0;
            buf_sel     <= 1'b0;
            stage_start <= '0;
            busy        <= 1'b0;
            done        <= 1'b1;
        end else begin
            case (ps)
                IDLE: begin
                    // buf_sel keeps its value so the result stays in bank buf_sel
                    if (start) begin
                        ps          <= ISSUE;
                        stg         <= '0;
                        round       <= '0;
                        stage_start <= FIRST_OH;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                    end
                end
                ISSUE: begin
                    ps          <= ARM;
                    stage_start <= '0;
                end
                ARM: begin
                    // done dropping confirms the stage took the start pulse
                    if (!act_done) begin
                        ps <= WAIT;
                    end
                end
                WAIT: begin
                    if (act_done) begin
                        ps <= ADVANCE;
                    end
                end
                ADVANCE: begin
                    buf_sel <= ~buf_sel;
                    if (stg != LAST_STG) begin
                        ps          <= ISSUE;
                        stg         <= stg + STG_W'(1);
                        stage_start <= FIRST_OH << (stg + STG_W'(1));
                    end else if (round != LAST_RND) begin
                        ps          <= ISSUE;
                        stg         <= '0;
                        round       <= round + RND_W'(1);
                        stage_start <= FIRST_OH;
                    end else begin
                        ps   <= IDLE;
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
                default: begin
                    ps          <= IDLE;
                    stage_start <= '0;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_round_sched_cu.sv
// Scoreboard bench for round_sched_cu: one instance with NUM_ROUNDS=1 and one
// with NUM_ROUNDS=2 share a behavioural model of the five stage controllers.
module tb_round_sched_cu;

    localparam int L = 4;

    typedef struct {
        bit         is_end;
        int         dut;
        logic [4:0] ss;
        logic [4:0] rnd;
        logic       bsel;
        int         gap;
        bit         first;
        int         total;
    } evt_t;

    logic       clk;
    logic       rst;
    logic       start_s [2];
    logic [4:0] sdone;
    logic [4:0] ss      [2];
    logic [4:0] rnd     [2];
    logic       bsel    [2];
    logic       busy    [2];
    logic       done    [2];

    logic [4:0] ss_any;
    logic [4:0] stall_arm  = '0;
    logic [4:0] stall_wait = '0;
    logic       noise_en   = 1'b0;
    logic       model_clr  = 1'b0;
    logic [4:0] noise_r    = '0;
    logic [4:0] act_oh     = '0;
    int         cnt [5]    = '{0, 0, 0, 0, 0};

    evt_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc     = 0;
    int   last_pulse [2] = '{0, 0};
    int   op_start   [2] = '{0, 0};
    logic prev_done  [2] = '{1'b1, 1'b1};

    round_sched_cu #(.NUM_ROUNDS(1)) u1 (
        .clk(clk), .rst(rst), .start(start_s[0]), .stage_done(sdone),
        .stage_start(ss[0]), .round(rnd[0]), .buf_sel(bsel[0]),
        .busy(busy[0]), .done(done[0])
    );

    round_sched_cu #(.NUM_ROUNDS(2)) u2 (
        .clk(clk), .rst(rst), .start(start_s[1]), .stage_done(sdone),
        .stage_start(ss[1]), .round(rnd[1]), .buf_sel(bsel[1]),
        .busy(busy[1]), .done(done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ss_any = ss[0] | ss[1];

    // Stage models: done low for L cycles after a start pulse, with optional stalls.
    always @(posedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (model_clr)
                cnt[i] <= 0;
            else if (ss_any[i] && !stall_arm[i])
                cnt[i] <= stall_wait[i] ? 1000000 : L;
            else if (cnt[i] > 0)
                cnt[i] <= cnt[i] - 1;
        end
        if (ss_any != 5'd0) act_oh <= ss_any;
        noise_r <= noise_en ? 5'($urandom) : 5'd0;
    end

    // Random chatter on the done flags of stages that are not active.
    always_comb begin
        sdone = '0;
        for (int i = 0; i < 5; i++)
            sdone[i] = (cnt[i] == 0) ^ (noise_r[i] & ~act_oh[i]);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic push_op(input int d, input int nr, input int npulse,
                           input logic b0, input int gap0, input bit with_end);
        evt_t e;
        for (int k = 0; k < npulse; k++) begin
            e.is_end = 1'b0;
            e.dut    = d;
            e.ss     = 5'(1 << (k % 5));
            e.rnd    = 5'(k / 5);
            e.bsel   = b0 ^ 1'(k % 2);
            e.gap    = (k == 0) ? gap0 : L + 3;
            e.first  = (k == 0);
            e.total  = 0;
            exp_q.push_back(e);
        end
        if (with_end) begin
            e.is_end = 1'b1;
            e.dut    = d;
            e.ss     = '0;
            e.rnd    = '0;
            e.bsel   = b0 ^ 1'(nr % 2);
            e.gap    = 0;
            e.first  = 1'b0;
            e.total  = 5 * nr * (L + 3);
            exp_q.push_back(e);
        end
    endtask

    task automatic monitor();
        evt_t e;
        forever begin
            @(negedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (rst) begin
                    prev_done[d] = 1'b1;
                end else begin
                    if (ss[d] != 5'd0) begin
                        if (exp_q.size() == 0 || exp_q[0].is_end || exp_q[0].dut != d) begin
                            chk($sformatf("d%0d unexpected pulse", d), int'(ss[d]), 0);
                        end else begin
                            e = exp_q.pop_front();
                            chk($sformatf("d%0d stage_start", d), int'(ss[d]), int'(e.ss));
                            chk($sformatf("d%0d round", d), int'(rnd[d]), int'(e.rnd));
                            chk($sformatf("d%0d buf_sel", d), int'(bsel[d]), int'(e.bsel));
                            if (e.gap != 0)
                                chk($sformatf("d%0d pulse gap", d), cyc - last_pulse[d], e.gap);
                            if (e.first) op_start[d] = cyc;
                        end
                        last_pulse[d] = cyc;
                    end
                    if (done[d] && !prev_done[d]) begin
                        if (exp_q.size() == 0 || !exp_q[0].is_end || exp_q[0].dut != d) begin
                            chk($sformatf("d%0d unexpected done", d), int'(done[d]), 0);
                        end else begin
                            e = exp_q.pop_front();
                            chk($sformatf("d%0d op latency", d), cyc - op_start[d], e.total);
                            chk($sformatf("d%0d final buf_sel", d), int'(bsel[d]), int'(e.bsel));
                        end
                    end
                    prev_done[d] = done[d];
                end
            end
        end
    endtask

    task automatic wait_empty(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        chk("pending expectations", exp_q.size(), 0);
    endtask

    task automatic pulse_start(input int d);
        @(posedge clk); #1;
        start_s[d] = 1'b1;
        @(posedge clk); #1;
        start_s[d] = 1'b0;
    endtask

    task automatic chk_reset(input int d, input string tag);
        chk($sformatf("%s d%0d stage_start", tag, d), int'(ss[d]), 0);
        chk($sformatf("%s d%0d round", tag, d), int'(rnd[d]), 0);
        chk($sformatf("%s d%0d buf_sel", tag, d), int'(bsel[d]), 0);
        chk($sformatf("%s d%0d busy", tag, d), int'(busy[d]), 0);
        chk($sformatf("%s d%0d done", tag, d), int'(done[d]), 1);
    endtask

    // Assert reset between edges and check outputs before the next edge.
    task automatic async_reset(input string tag);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk_reset(0, tag);
        chk_reset(1, tag);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        async_reset("idle reset");

        // Single round on the NUM_ROUNDS=1 instance
        push_op(0, 1, 5, 1'b0, 0, 1'b1);
        pulse_start(0);
        wait_empty(200);

        // Two rounds: stray start while busy, chatter on idle done flags in round 1
        push_op(1, 2, 10, 1'b0, 0, 1'b1);
        pulse_start(1);
        repeat (15) @(posedge clk);
        #1 start_s[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1 start_s[1] = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (rnd[1] == 5'd1) break;
            @(posedge clk); #1;
        end
        chk("round reaches 1", int'(rnd[1]), 1);
        noise_en = 1'b1;
        wait_empty(300);
        noise_en = 1'b0;

        // Reset during round 1, stage pi
        push_op(1, 2, 8, 1'b0, 0, 1'b0);
        pulse_start(1);
        wait_empty(300);
        repeat (2) @(posedge clk);
        async_reset("midop reset");
        repeat (8) @(posedge clk);

        // start held high: restart on the single Idle cycle
        push_op(1, 2, 10, 1'b0, 0, 1'b1);
        push_op(1, 2, 10, 1'b0, L + 4, 1'b1);
        @(posedge clk); #1 start_s[1] = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() <= 10) break;
            @(posedge clk);
        end
        #1 start_s[1] = 1'b0;
        wait_empty(300);

        // theta never accepts: stuck in Arm
        stall_arm = 5'b00001;
        push_op(1, 2, 1, 1'b0, 0, 1'b0);
        pulse_start(1);
        repeat (40) @(posedge clk);
        #1;
        chk("arm stall busy", int'(busy[1]), 1);
        chk("arm stall done", int'(done[1]), 0);
        chk("arm stall stage_start", int'(ss[1]), 0);
        chk("arm stall queue", exp_q.size(), 0);
        async_reset("arm stall reset");
        stall_arm = 5'b00000;

        // chi never finishes: stuck in Wait
        stall_wait = 5'b01000;
        push_op(1, 2, 4, 1'b0, 0, 1'b0);
        pulse_start(1);
        repeat (60) @(posedge clk);
        #1;
        chk("wait stall busy", int'(busy[1]), 1);
        chk("wait stall round", int'(rnd[1]), 0);
        chk("wait stall queue", exp_q.size(), 0);
        async_reset("wait stall reset");
        model_clr = 1'b1;
        @(posedge clk); #1;
        model_clr  = 1'b0;
        stall_wait = 5'b00000;
        repeat (5) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
